// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues I-cache reads, absorbs misses,
// hazard stalls and branch/jump redirects, and feeds IF_ID_reg.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_write,
  input  logic        backend_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        ICACHE_ren,
  output logic [29:0] ICACHE_addr,
  input  logic [31:0] ICACHE_rdata,
  input  logic        ICACHE_stall,
  output logic [31:0] PC_4,
  output logic [31:0] inst,
  output logic        if_valid,
  output logic        IF_flush
);

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_hold_buf;
  logic [31:0] r_redir_buf;

  logic        w_advance;
  logic        w_acc_redir;
  logic [31:0] w_target;
  logic [31:0] w_pc_4;

  assign w_advance   = pc_write & ~backend_stall;
  assign w_acc_redir = redirect_valid & ~backend_stall;
  assign w_target    = redirect_target & ~32'h0000_0003;
  assign w_pc_4      = r_pc + 32'd4;

  // In DRAIN the pc still holds the abandoned request's address, keeping addr stable.
  assign ICACHE_ren  = rst_n & ((r_state == FETCH) | (r_state == DRAIN));
  assign ICACHE_addr = r_pc[31:2];
  assign PC_4        = w_pc_4;
  assign IF_flush    = w_acc_redir;

  always_comb begin
    inst     = 32'h0;
    if_valid = 1'b0;
    case (r_state)
      FETCH: begin
        if (!ICACHE_stall) begin
          inst     = ICACHE_rdata;
          if_valid = 1'b1;
        end
      end
      HOLD: begin
        inst     = r_hold_buf;
        if_valid = 1'b1;
      end
      default: begin
        inst     = 32'h0;
        if_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC;
      r_state     <= FETCH;
      r_hold_buf  <= 32'h0;
      r_redir_buf <= 32'h0;
    end else begin
      case (r_state)
        FETCH: begin
          if (!ICACHE_stall) begin
            if (w_acc_redir) begin
              r_pc <= w_target;
            end else if (w_advance) begin
              r_pc <= w_pc_4;
            end else begin
              r_hold_buf <= ICACHE_rdata;
              r_state    <= HOLD;
            end
          end else if (w_acc_redir) begin
            r_redir_buf <= w_target;
            r_state     <= DRAIN;
          end
        end
        HOLD: begin
          if (w_acc_redir) begin
            r_pc    <= w_target;
            r_state <= FETCH;
          end else if (w_advance) begin
            r_pc    <= w_pc_4;
            r_state <= FETCH;
          end
        end
        DRAIN: begin
          // A redirect arriving on the completing cycle is newer than redir_buf.
          if (!ICACHE_stall) begin
            r_pc    <= w_acc_redir ? w_target : r_redir_buf;
            r_state <= FETCH;
          end else if (w_acc_redir) begin
            r_redir_buf <= w_target;
          end
        end
        default: begin
          r_state <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: each driven cycle pushes its expected
// outputs, which are popped and compared half a clock later.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_write;
  logic        backend_stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        ICACHE_ren;
  logic [29:0] ICACHE_addr;
  logic [31:0] ICACHE_rdata;
  logic        ICACHE_stall;
  logic [31:0] PC_4;
  logic [31:0] inst;
  logic        if_valid;
  logic        IF_flush;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic        full;
    logic        ren;
    logic [29:0] addr;
    logic        v;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        fl;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_write       (pc_write),
    .backend_stall  (backend_stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .ICACHE_ren     (ICACHE_ren),
    .ICACHE_addr    (ICACHE_addr),
    .ICACHE_rdata   (ICACHE_rdata),
    .ICACHE_stall   (ICACHE_stall),
    .PC_4           (PC_4),
    .inst           (inst),
    .if_valid       (if_valid),
    .IF_flush       (IF_flush)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, push expectation, then pop and compare on the falling edge.
  task automatic cyc(input string tag, input logic rn, input logic pw, input logic bs,
                     input logic rv, input logic [31:0] rt, input logic st,
                     input logic [31:0] rd, input logic full, input logic e_ren,
                     input logic [29:0] e_addr, input logic e_v, input logic [31:0] e_inst,
                     input logic [31:0] e_pc4, input logic e_fl);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rn; pc_write = pw; backend_stall = bs; redirect_valid = rv;
    redirect_target = rt; ICACHE_stall = st; ICACHE_rdata = rd;
    e.tag = tag; e.full = full; e.ren = e_ren; e.addr = e_addr; e.v = e_v;
    e.inst = e_inst; e.pc4 = e_pc4; e.fl = e_fl;
    sb_q.push_back(e);
    @(negedge clk);
    e = sb_q.pop_front();
    check_eq({e.tag, ".ren"}, {31'h0, ICACHE_ren}, {31'h0, e.ren});
    check_eq({e.tag, ".pc4"}, PC_4, e.pc4);
    if (e.full) begin
      check_eq({e.tag, ".addr"}, {2'b0, ICACHE_addr}, {2'b0, e.addr});
      check_eq({e.tag, ".valid"}, {31'h0, if_valid}, {31'h0, e.v});
      check_eq({e.tag, ".inst"}, inst, e.inst);
      check_eq({e.tag, ".flush"}, {31'h0, IF_flush}, {31'h0, e.fl});
    end
    $display("cycle %-10s ren=%0d addr=%08h v=%0d inst=%08h pc4=%08h fl=%0d",
             e.tag, ICACHE_ren, ICACHE_addr, if_valid, inst, PC_4, IF_flush);
  endtask

  initial begin
    rst_n = 1'b0; pc_write = 1'b0; backend_stall = 1'b0; redirect_valid = 1'b0;
    redirect_target = 32'h0; ICACHE_stall = 1'b0; ICACHE_rdata = 32'h0;
    repeat (2) @(posedge clk);

    //   tag         rn pw bs rv target        st rdata          full ren addr          v  inst           pc4            fl
    cyc("rst",       0, 1, 0, 0, 32'h0,        0, 32'h1111_0000, 0,   0, 30'h0,        0, 32'h0,         32'h4,         0);
    // back-to-back hits
    cyc("hit0",      1, 1, 0, 0, 32'h0,        0, 32'hA000_0000, 1,   1, 30'h0,        1, 32'hA000_0000, 32'h4,         0);
    cyc("hit1",      1, 1, 0, 0, 32'h0,        0, 32'hA000_0001, 1,   1, 30'h1,        1, 32'hA000_0001, 32'h8,         0);
    cyc("hit2",      1, 1, 0, 0, 32'h0,        0, 32'hA000_0002, 1,   1, 30'h2,        1, 32'hA000_0002, 32'hC,         0);
    cyc("hit3",      1, 1, 0, 0, 32'h0,        0, 32'hA000_0003, 1,   1, 30'h3,        1, 32'hA000_0003, 32'h10,        0);
    // 3-cycle miss at 0x10
    cyc("miss0",     1, 1, 0, 0, 32'h0,        1, 32'hBBBB_BBBB, 1,   1, 30'h4,        0, 32'h0,         32'h14,        0);
    cyc("miss1",     1, 1, 0, 0, 32'h0,        1, 32'hBBBB_BBBB, 1,   1, 30'h4,        0, 32'h0,         32'h14,        0);
    cyc("miss2",     1, 1, 0, 0, 32'h0,        1, 32'hBBBB_BBBB, 1,   1, 30'h4,        0, 32'h0,         32'h14,        0);
    cyc("missdone",  1, 1, 0, 0, 32'h0,        0, 32'h8C22_0000, 1,   1, 30'h4,        1, 32'h8C22_0000, 32'h14,        0);
    // load-use hold
    cyc("holdhit",   1, 0, 0, 0, 32'h0,        0, 32'hDEAD_BEEF, 1,   1, 30'h5,        1, 32'hDEAD_BEEF, 32'h18,        0);
    cyc("hold1",     1, 0, 0, 0, 32'h0,        0, 32'h1234_5678, 1,   0, 30'h5,        1, 32'hDEAD_BEEF, 32'h18,        0);
    cyc("holdrel",   1, 1, 0, 0, 32'h0,        0, 32'h1234_5678, 1,   0, 30'h5,        1, 32'hDEAD_BEEF, 32'h18,        0);
    cyc("afthold",   1, 1, 0, 0, 32'h0,        0, 32'hA000_0006, 1,   1, 30'h6,        1, 32'hA000_0006, 32'h1C,        0);
    cyc("hit7",      1, 1, 0, 0, 32'h0,        0, 32'hA000_0007, 1,   1, 30'h7,        1, 32'hA000_0007, 32'h20,        0);
    // redirect on a hit, low target bits ignored
    cyc("redirhit",  1, 1, 0, 1, 32'h103,      0, 32'hA000_0008, 1,   1, 30'h8,        1, 32'hA000_0008, 32'h24,        1);
    cyc("redirtgt",  1, 1, 0, 0, 32'h0,        0, 32'hA000_0040, 1,   1, 30'h40,       1, 32'hA000_0040, 32'h104,       0);
    cyc("tojump30",  1, 1, 0, 1, 32'h30,       0, 32'hA000_0041, 1,   1, 30'h41,       1, 32'hA000_0041, 32'h108,       1);
    // redirect during a 4-cycle miss
    cyc("drain0",    1, 1, 0, 1, 32'h200,      1, 32'hBAD0_0000, 1,   1, 30'hC,        0, 32'h0,         32'h34,        1);
    cyc("drain1",    1, 1, 0, 0, 32'h0,        1, 32'hBAD0_0000, 1,   1, 30'hC,        0, 32'h0,         32'h34,        0);
    cyc("drain2",    1, 1, 0, 0, 32'h0,        1, 32'hBAD0_0000, 1,   1, 30'hC,        0, 32'h0,         32'h34,        0);
    cyc("drain3",    1, 1, 0, 0, 32'h0,        1, 32'hBAD0_0000, 1,   1, 30'hC,        0, 32'h0,         32'h34,        0);
    cyc("draindone", 1, 1, 0, 0, 32'h0,        0, 32'hBAD0_0001, 1,   1, 30'hC,        0, 32'h0,         32'h34,        0);
    cyc("aftdrain",  1, 1, 0, 0, 32'h0,        0, 32'hA000_0080, 1,   1, 30'h80,       1, 32'hA000_0080, 32'h204,       0);
    // two redirects in one drain: newest wins
    cyc("dd0",       1, 1, 0, 1, 32'h300,      1, 32'hBAD0_0002, 1,   1, 30'h81,       0, 32'h0,         32'h208,       1);
    cyc("dd1",       1, 1, 0, 1, 32'h400,      1, 32'hBAD0_0002, 1,   1, 30'h81,       0, 32'h0,         32'h208,       1);
    cyc("dddone",    1, 1, 0, 0, 32'h0,        0, 32'hBAD0_0003, 1,   1, 30'h81,       0, 32'h0,         32'h208,       0);
    // backend_stall masks redirect and advance
    cyc("bstall",    1, 1, 1, 1, 32'h500,      0, 32'hA000_0100, 1,   1, 30'h100,      1, 32'hA000_0100, 32'h404,       0);
    cyc("holdredir", 1, 1, 0, 1, 32'h500,      0, 32'h5555_5555, 1,   0, 30'h100,      1, 32'hA000_0100, 32'h404,       1);
    cyc("at500",     1, 1, 0, 1, 32'hFFFF_FFFF,0, 32'hA000_0140, 1,   1, 30'h140,      1, 32'hA000_0140, 32'h504,       1);
    // PC wrap
    cyc("wrap",      1, 1, 0, 0, 32'h0,        0, 32'hA3FF_FFFF, 1,   1, 30'h3FFF_FFFF,1, 32'hA3FF_FFFF, 32'h0,         0);
    cyc("wrapped",   1, 1, 0, 0, 32'h0,        0, 32'hA000_0000, 1,   1, 30'h0,        1, 32'hA000_0000, 32'h4,         0);
    // reset during a miss
    cyc("rmiss",     1, 1, 0, 0, 32'h0,        1, 32'hBAD0_0004, 1,   1, 30'h1,        0, 32'h0,         32'h8,         0);
    cyc("rmrst0",    0, 1, 0, 0, 32'h0,        1, 32'hBAD0_0004, 0,   0, 30'h1,        0, 32'h0,         32'h8,         0);
    cyc("rmrst1",    0, 1, 0, 0, 32'h0,        1, 32'hBAD0_0004, 0,   0, 30'h0,        0, 32'h0,         32'h4,         0);
    cyc("rmrel",     1, 1, 0, 0, 32'h0,        0, 32'hA000_0000, 1,   1, 30'h0,        1, 32'hA000_0000, 32'h4,         0);

    check_eq("sb_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
